// File: rtl/overture_control_pkg.sv
// Shared types and constants for the overture_control sequencer.
package overture_pkg;

    typedef enum logic [1:0] {
        IMM  = 2'b00,
        CALC = 2'b01,
        COPY = 2'b10,
        COND = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        COND_NEVER  = 3'd0,
        COND_EQ     = 3'd1,
        COND_LT     = 3'd2,
        COND_LE     = 3'd3,
        COND_ALWAYS = 3'd4,
        COND_NE     = 3'd5,
        COND_GE     = 3'd6,
        COND_GT     = 3'd7
    } cond_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        IO_IN  = 2'd2,
        IO_OUT = 2'd3
    } state_t;

    localparam logic [2:0] IO_INDEX   = 3'd6;
    localparam logic [2:0] NULL_INDEX = 3'd7;
    localparam int         NUM_REGS   = 6;

endpackage

// File: rtl/overture_control_cond_eval.sv
// Combinational branch-condition evaluator: tests a signed byte against a cond_t code.
module overture_cond_eval
    import overture_pkg::*;
(
    input  cond_t             cond,
    input  logic signed [7:0] value,
    output logic              taken
);

    logic is_zero_s;
    logic is_neg_s;

    assign is_zero_s = (value == 8'sd0);
    assign is_neg_s  = value[7];

    // Condition decode
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NEVER:  taken = 1'b0;
            COND_EQ:     taken = is_zero_s;
            COND_LT:     taken = is_neg_s;
            COND_LE:     taken = is_neg_s | is_zero_s;
            COND_ALWAYS: taken = 1'b1;
            COND_NE:     taken = ~is_zero_s;
            COND_GE:     taken = ~is_neg_s;
            COND_GT:     taken = ~is_neg_s & ~is_zero_s;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/overture_control.sv
// Fetch/decode/execute sequencer driving the 8-bit ALU and an 8-bit I/O port.
// Optional single-step gating enabled by defining OVERTURE_CONTROL_STEP_EN.
module overture_control
    import overture_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] progAddr,
    output logic       progReq,
    input  logic [7:0] progData,
    input  logic       progValid,
    output logic [2:0] aluOpcode,
    output logic [7:0] aluOperandA,
    output logic [7:0] aluOperandB,
    input  logic [7:0] aluResult,
    input  logic [7:0] ioIn,
    input  logic       ioInValid,
    output logic       ioInReady,
    output logic [7:0] ioOut,
    output logic       ioOutValid,
    input  logic       ioOutReady
`ifdef OVERTURE_CONTROL_STEP_EN
    ,
    input  logic       stepReq,
    output logic       idle
`endif
);

    state_t     state_r;
    logic [7:0] pc_r;
    logic [7:0] ir_r;
    logic [7:0] regs_r [0:NUM_REGS-1];
    logic [7:0] io_out_r;
    logic       io_out_valid_r;
    logic       io_in_ready_r;

    mode_t      mode_s;
    logic [2:0] src_s;
    logic [2:0] dst_s;
    logic [7:0] pc_inc_s;
    logic [7:0] src_val_s;
    logic       taken_s;
    logic       prog_req_s;
    logic       fetch_go_s;

    assign mode_s     = mode_t'(ir_r[7:6]);
    assign src_s      = ir_r[5:3];
    assign dst_s      = ir_r[2:0];
    assign pc_inc_s   = pc_r + 8'd1;
    assign fetch_go_s = prog_req_s & progValid;

    assign progAddr    = pc_r;
    assign progReq     = prog_req_s;
    assign aluOpcode   = ir_r[2:0];
    assign aluOperandA = regs_r[1];
    assign aluOperandB = regs_r[2];
    assign ioOut       = io_out_r;
    assign ioOutValid  = io_out_valid_r;
    assign ioInReady   = io_in_ready_r;

`ifdef OVERTURE_CONTROL_STEP_EN
    logic step_pending_r;

    assign prog_req_s = (state_r == FETCH) & step_pending_r;
    assign idle       = (state_r == FETCH) & ~step_pending_r;

    // Step latch: a newly arriving pulse wins over the clear so it is never lost
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            step_pending_r <= 1'b0;
        end else if (stepReq) begin
            step_pending_r <= 1'b1;
        end else if (fetch_go_s) begin
            step_pending_r <= 1'b0;
        end else begin
            step_pending_r <= step_pending_r;
        end
    end
`else
    assign prog_req_s = (state_r == FETCH);
`endif

    // COPY source mux: index 7 reads as zero, I/O is handled by the FSM
    always_comb begin
        src_val_s = 8'h00;
        case (src_s)
            3'd0:    src_val_s = regs_r[0];
            3'd1:    src_val_s = regs_r[1];
            3'd2:    src_val_s = regs_r[2];
            3'd3:    src_val_s = regs_r[3];
            3'd4:    src_val_s = regs_r[4];
            3'd5:    src_val_s = regs_r[5];
            default: src_val_s = 8'h00;
        endcase
    end

    overture_cond_eval u_cond_eval (
        .cond  (cond_t'(ir_r[2:0])),
        .value ($signed(regs_r[3])),
        .taken (taken_s)
    );

    // Sequencer FSM with register file and registered I/O handshake outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r        <= FETCH;
            pc_r           <= RESET_PC;
            ir_r           <= 8'h00;
            io_out_r       <= 8'h00;
            io_out_valid_r <= 1'b0;
            io_in_ready_r  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else begin
            case (state_r)
                FETCH: begin
                    if (fetch_go_s) begin
                        ir_r    <= progData;
                        state_r <= EXEC;
                    end
                end
                EXEC: begin
                    case (mode_s)
                        IMM: begin
                            regs_r[0] <= {2'b00, ir_r[5:0]};
                            pc_r      <= pc_inc_s;
                            state_r   <= FETCH;
                        end
                        CALC: begin
                            regs_r[3] <= aluResult;
                            pc_r      <= pc_inc_s;
                            state_r   <= FETCH;
                        end
                        COPY: begin
                            if (src_s == IO_INDEX) begin
                                io_in_ready_r <= 1'b1;
                                state_r       <= IO_IN;
                            end else if (dst_s == IO_INDEX) begin
                                io_out_r       <= src_val_s;
                                io_out_valid_r <= 1'b1;
                                state_r        <= IO_OUT;
                            end else begin
                                if (dst_s != NULL_INDEX) begin
                                    regs_r[dst_s] <= src_val_s;
                                end
                                pc_r    <= pc_inc_s;
                                state_r <= FETCH;
                            end
                        end
                        COND: begin
                            pc_r    <= taken_s ? regs_r[0] : pc_inc_s;
                            state_r <= FETCH;
                        end
                        default: state_r <= FETCH;
                    endcase
                end
                IO_IN: begin
                    if (ioInValid) begin
                        io_in_ready_r <= 1'b0;
                        if (dst_s == IO_INDEX) begin
                            io_out_r       <= ioIn;
                            io_out_valid_r <= 1'b1;
                            state_r        <= IO_OUT;
                        end else begin
                            if (dst_s != NULL_INDEX) begin
                                regs_r[dst_s] <= ioIn;
                            end
                            pc_r    <= pc_inc_s;
                            state_r <= FETCH;
                        end
                    end
                end
                IO_OUT: begin
                    if (ioOutReady) begin
                        io_out_valid_r <= 1'b0;
                        pc_r           <= pc_inc_s;
                        state_r        <= FETCH;
                    end
                end
                default: begin
                    io_in_ready_r  <= 1'b0;
                    io_out_valid_r <= 1'b0;
                    state_r        <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_overture_control.sv
// Self-checking bench for overture_control: directed plan steps, then random programs
// checked against an instruction-level reference model.
module tb_overture_control;

    logic       clock;
    logic       reset;
    logic [7:0] progAddr;
    logic       progReq;
    logic [7:0] progData;
    logic       progValid;
    logic [2:0] aluOpcode;
    logic [7:0] aluOperandA;
    logic [7:0] aluOperandB;
    logic [7:0] aluResult;
    logic [7:0] ioIn;
    logic       ioInValid;
    logic       ioInReady;
    logic [7:0] ioOut;
    logic       ioOutValid;
    logic       ioOutReady;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    logic [7:0] m_regs [0:5];
    logic [7:0] m_pc;

    overture_control #(.RESET_PC(8'h00)) dut (
        .clock       (clock),
        .reset       (reset),
        .progAddr    (progAddr),
        .progReq     (progReq),
        .progData    (progData),
        .progValid   (progValid),
        .aluOpcode   (aluOpcode),
        .aluOperandA (aluOperandA),
        .aluOperandB (aluOperandB),
        .aluResult   (aluResult),
        .ioIn        (ioIn),
        .ioInValid   (ioInValid),
        .ioInReady   (ioInReady),
        .ioOut       (ioOut),
        .ioOutValid  (ioOutValid),
        .ioOutReady  (ioOutReady)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in for the existing ALU; opcodes 6 and 7 return zero
    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~a;
            3'd4:    return a + b;
            3'd5:    return a - b;
            default: return 8'h00;
        endcase
    endfunction

    always_comb aluResult = alu_fn(aluOpcode, aluOperandA, aluOperandB);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 8'h00;
        for (int i = 0; i < 6; i++) m_regs[i] = 8'h00;
    endtask

    // Instruction-level reference: one call retires one instruction
    task automatic model_exec(input logic [7:0] instr, input logic [7:0] in_data, output logic [7:0] out_val);
        int mode, src, dst, cnd, s;
        logic [7:0] v;
        bit taken;
        mode = int'(instr) / 64;
        src  = (int'(instr) / 8) % 8;
        dst  = int'(instr) % 8;
        out_val = 8'h00;
        if (mode == 0) begin
            m_regs[0] = instr % 8'd64;
            m_pc = m_pc + 8'd1;
        end else if (mode == 1) begin
            m_regs[3] = alu_fn(instr[2:0], m_regs[1], m_regs[2]);
            m_pc = m_pc + 8'd1;
        end else if (mode == 2) begin
            v = (src == 6) ? in_data : (src == 7) ? 8'h00 : m_regs[src];
            if (dst == 6) out_val = v;
            else if (dst < 6) m_regs[dst] = v;
            m_pc = m_pc + 8'd1;
        end else begin
            s   = (m_regs[3] >= 8'd128) ? int'(m_regs[3]) - 256 : int'(m_regs[3]);
            cnd = dst;
            case (cnd)
                0: taken = 1'b0;
                1: taken = (s == 0);
                2: taken = (s < 0);
                3: taken = (s <= 0);
                4: taken = 1'b1;
                5: taken = (s != 0);
                6: taken = (s >= 0);
                default: taken = (s > 0);
            endcase
            m_pc = taken ? m_regs[0] : m_pc + 8'd1;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_pc"}, progAddr, m_pc);
        chk({tag, "_req"}, progReq, 1'b1);
        chk({tag, "_ovalid"}, ioOutValid, 1'b0);
        chk({tag, "_iready"}, ioInReady, 1'b0);
        chk({tag, "_r0"}, dut.regs_r[0], m_regs[0]);
        chk({tag, "_r1"}, aluOperandA, m_regs[1]);
        chk({tag, "_r2"}, aluOperandB, m_regs[2]);
        chk({tag, "_r3"}, dut.regs_r[3], m_regs[3]);
        chk({tag, "_r4"}, dut.regs_r[4], m_regs[4]);
        chk({tag, "_r5"}, dut.regs_r[5], m_regs[5]);
    endtask

    // Runs one instruction through every handshake it needs, then checks architectural state
    task automatic do_instr(input string tag, input logic [7:0] instr, input int in_wait,
                            input logic [7:0] in_data, input int out_wait);
        logic [7:0] exp_out;
        bit needs_in, needs_out;
        needs_in  = (instr[7:6] == 2'b10) && (instr[5:3] == 3'd6);
        needs_out = (instr[7:6] == 2'b10) && (instr[2:0] == 3'd6);
        chk({tag, "_fetch_req"}, progReq, 1'b1);
        chk({tag, "_fetch_addr"}, progAddr, m_pc);
        progData  = instr;
        progValid = 1'b1;
        @(posedge clock); #1;
        progValid = 1'b0;
        progData  = 8'($urandom);
        chk({tag, "_exec_noreq"}, progReq, 1'b0);
        if (instr[7:6] == 2'b01) chk({tag, "_aluop"}, aluOpcode, instr[2:0]);
        @(posedge clock); #1;
        if (needs_in) begin
            for (int i = 0; i < in_wait; i++) begin
                chk({tag, "_in_wait_ready"}, ioInReady, 1'b1);
                ioIn = 8'($urandom);
                @(posedge clock); #1;
            end
            chk({tag, "_in_ready"}, ioInReady, 1'b1);
            ioIn      = in_data;
            ioInValid = 1'b1;
            @(posedge clock); #1;
            ioInValid = 1'b0;
        end
        model_exec(instr, in_data, exp_out);
        if (needs_out) begin
            for (int i = 0; i < out_wait; i++) begin
                chk({tag, "_out_valid_hold"}, ioOutValid, 1'b1);
                chk({tag, "_out_data_hold"}, ioOut, exp_out);
                chk({tag, "_out_noreq"}, progReq, 1'b0);
                @(posedge clock); #1;
            end
            chk({tag, "_out_valid"}, ioOutValid, 1'b1);
            chk({tag, "_out_data"}, ioOut, exp_out);
            ioOutReady = 1'b1;
            @(posedge clock); #1;
            ioOutReady = 1'b0;
        end
        check_state(tag);
    endtask

    initial begin
        reset      = 1'b0;
        progData   = 8'h00;
        progValid  = 1'b0;
        ioIn       = 8'h00;
        ioInValid  = 1'b0;
        ioOutReady = 1'b0;
        model_reset();

        #1 reset = 1'b1;
        #2;
        chk("rst_req", progReq, 1'b1);
        chk("rst_pc", progAddr, 8'h00);
        chk("rst_ovalid", ioOutValid, 1'b0);
        chk("rst_out", ioOut, 8'h00);
        chk("rst_iready", ioInReady, 1'b0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        check_state("after_rst");

        do_instr("imm3f", 8'h3F, 0, 8'h00, 0);
        chk("imm3f_r0", dut.regs_r[0], 8'h3F);
        chk("imm3f_pc1", progAddr, 8'h01);
        do_instr("imm05", 8'h05, 0, 8'h00, 0);
        do_instr("cp01", 8'h81, 0, 8'h00, 0);
        do_instr("in_f9", 8'hB0, 0, 8'hF9, 0);
        do_instr("cp02", 8'h82, 0, 8'h00, 0);
        do_instr("add", 8'h44, 0, 8'h00, 0);
        chk("add_r3", dut.regs_r[3], 8'hFE);
        do_instr("imm10", 8'h10, 0, 8'h00, 0);
        do_instr("cond_lt", 8'hC2, 0, 8'h00, 0);
        chk("cond_lt_pc", progAddr, 8'h10);
        do_instr("cond_gt", 8'hC7, 0, 8'h00, 0);
        chk("cond_gt_pc", progAddr, 8'h11);
        do_instr("in_a5", 8'hB0, 3, 8'hA5, 0);
        chk("in_a5_r0", dut.regs_r[0], 8'hA5);
        chk("in_a5_pc", progAddr, 8'h12);
        do_instr("out_r3", 8'h9E, 0, 8'h00, 4);
        chk("out_r3_pc", progAddr, 8'h13);

        // Reset while an output is waiting on the sink
        progData  = 8'h9E;
        progValid = 1'b1;
        @(posedge clock); #1;
        progValid = 1'b0;
        @(posedge clock); #1;
        chk("mid_out_valid", ioOutValid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_ovalid", ioOutValid, 1'b0);
        chk("mid_rst_req", progReq, 1'b1);
        chk("mid_rst_pc", progAddr, 8'h00);
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
        check_state("mid_rst");

        // pc wrap from 8'hFF
        do_instr("in_ff", 8'hB0, 0, 8'hFF, 0);
        do_instr("jmp_ff", 8'hC4, 0, 8'h00, 0);
        chk("jmp_ff_pc", progAddr, 8'hFF);
        do_instr("wrap", 8'h01, 0, 8'h00, 0);
        chk("wrap_pc", progAddr, 8'h00);

        for (int n = 0; n < 200; n++) begin
            do_instr("rnd", 8'($urandom), int'($urandom_range(0, 2)), 8'($urandom),
                     int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
